// File: rtl/simmem_pkg.sv
// Shared types and timing constants for the simulated DRAM memory model.
// Address/request layout and row-buffer cost parameters.
package simmem_pkg;

  localparam int unsigned AxAddrWidth       = 16;
  localparam int unsigned RowBufferLenWidth = 8;
  localparam int unsigned RowIdWidth        = AxAddrWidth - RowBufferLenWidth;
  localparam int unsigned IDWidth           = 6;
  localparam int unsigned BurstLenWidth     = 8;
  localparam int unsigned CostWidth         = 10;

  localparam int unsigned RowHitCost     = 10;
  localparam int unsigned PrechargeCost  = 50;
  localparam int unsigned ActivationCost = 45;

  typedef enum logic [1:0] {
    RowHit,
    RowEmpty,
    RowMiss
  } row_access_e;

  typedef struct packed {
    logic [IDWidth-1:0]       id;
    logic [AxAddrWidth-1:0]   addr;
    logic [BurstLenWidth-1:0] burst_length;
  } raddr_req_t;

  typedef struct packed {
    logic [IDWidth-1:0]       id;
    logic [AxAddrWidth-1:0]   addr;
    logic [BurstLenWidth-1:0] burst_length;
  } waddr_req_t;

  function automatic logic [RowIdWidth-1:0] row_of(
    input logic [AxAddrWidth-1:0] addr
  );
    return RowIdWidth'(addr >> RowBufferLenWidth);
  endfunction

endpackage

// File: rtl/simmem_row_scheduler_if.sv
// Address-request and release handshakes of the row scheduler.
// Signal names are seen from the scheduler side.
interface simmem_row_scheduler_if;
  import simmem_pkg::*;

  raddr_req_t             raddr_i;
  logic                   raddr_valid_i;
  logic                   raddr_ready_o;
  waddr_req_t             waddr_i;
  logic                   waddr_valid_i;
  logic                   waddr_ready_o;
  logic                   release_valid_o;
  logic                   release_ready_i;
  logic [IDWidth-1:0]     release_id_o;
  logic                   release_is_write_o;
  logic [1:0]             release_kind_o;

  modport master (
    output raddr_i, raddr_valid_i,
    input  raddr_ready_o,
    output waddr_i, waddr_valid_i,
    input  waddr_ready_o,
    input  release_valid_o,
    output release_ready_i,
    input  release_id_o, release_is_write_o, release_kind_o
  );

  modport slave (
    input  raddr_i, raddr_valid_i,
    output raddr_ready_o,
    input  waddr_i, waddr_valid_i,
    output waddr_ready_o,
    output release_valid_o,
    input  release_ready_i,
    output release_id_o, release_is_write_o, release_kind_o
  );

endinterface

// File: rtl/simmem_row_cost.sv
// Classifies an access against the open row and returns its service delay.
// Purely combinational.
module simmem_row_cost
  import simmem_pkg::*;
(
  input  logic [AxAddrWidth-1:0]   addr,
  input  logic [BurstLenWidth-1:0] burst_length,
  input  logic [RowIdWidth-1:0]    open_row,
  input  logic                     open_valid,
  output row_access_e              kind,
  output logic [CostWidth-1:0]     cost
);

  logic [RowIdWidth-1:0] row;
  logic [CostWidth-1:0]  len;
  logic                  same;

  assign row  = row_of(addr);
  assign len  = CostWidth'(burst_length);
  assign same = (row == open_row);

  always_comb begin
    kind = RowEmpty;
    cost = CostWidth'(ActivationCost + RowHitCost) + len;
    unique case (1'b1)
      !open_valid: begin
        kind = RowEmpty;
        cost = CostWidth'(ActivationCost + RowHitCost) + len;
      end
      open_valid && same: begin
        kind = RowHit;
        cost = CostWidth'(RowHitCost) + len;
      end
      open_valid && !same: begin
        kind = RowMiss;
        cost = CostWidth'(PrechargeCost + ActivationCost + RowHitCost) + len;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/simmem_row_scheduler.sv
// Single-bank row scheduler: round-robin read/write grant, row-aware delay,
// then a registered release handshake toward the response banks.
module simmem_row_scheduler
  import simmem_pkg::*;
(
  input logic                   clk_i,
  input logic                   rst_i,
  simmem_row_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    Idle,
    Service,
    Release
  } state_e;

  state_e                 state, state_d;
  logic [CostWidth-1:0]   cnt, cnt_d;
  logic                   do_grant;

  raddr_req_t             r_req;
  waddr_req_t             w_req;
  logic                   r_full, w_full;
  logic                   last_write;

  logic [RowIdWidth-1:0]  open_row;
  logic                   open_valid;

  logic [IDWidth-1:0]     rel_id;
  logic                   rel_is_write;
  row_access_e            rel_kind;

  logic                   grant_w;
  logic [IDWidth-1:0]     sel_id;
  logic [AxAddrWidth-1:0] sel_addr;
  logic [BurstLenWidth-1:0] sel_len;
  row_access_e            kind;
  logic [CostWidth-1:0]   cost;

  // On a tie the side that did not win last time is served.
  assign grant_w  = w_full && (!r_full || !last_write);
  assign sel_id   = grant_w ? w_req.id : r_req.id;
  assign sel_addr = grant_w ? w_req.addr : r_req.addr;
  assign sel_len  = grant_w ? w_req.burst_length : r_req.burst_length;

  simmem_row_cost u_cost (
    .addr         (sel_addr),
    .burst_length (sel_len),
    .open_row     (open_row),
    .open_valid   (open_valid),
    .kind         (kind),
    .cost         (cost)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= Idle;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    do_grant = 1'b0;
    unique case (state)
      Idle: begin
        if (r_full || w_full) begin
          do_grant = 1'b1;
          cnt_d    = cost - CostWidth'(1);
          state_d  = Service;
        end
      end
      Service: begin
        if (cnt == '0) state_d = Release;
        else cnt_d = cnt - CostWidth'(1);
      end
      Release: begin
        if (bus.release_ready_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_full <= 1'b0;
      w_full <= 1'b0;
      r_req  <= '0;
      w_req  <= '0;
    end else begin
      if (do_grant && !grant_w) r_full <= 1'b0;
      else if (bus.raddr_valid_i && !r_full) begin
        r_full <= 1'b1;
        r_req  <= bus.raddr_i;
      end
      if (do_grant && grant_w) w_full <= 1'b0;
      else if (bus.waddr_valid_i && !w_full) begin
        w_full <= 1'b1;
        w_req  <= bus.waddr_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_write   <= 1'b1;
      open_row     <= '0;
      open_valid   <= 1'b0;
      rel_id       <= '0;
      rel_is_write <= 1'b0;
      rel_kind     <= RowHit;
    end else if (do_grant) begin
      last_write   <= grant_w;
      open_row     <= row_of(sel_addr);
      open_valid   <= 1'b1;
      rel_id       <= sel_id;
      rel_is_write <= grant_w;
      rel_kind     <= kind;
    end
  end

  assign bus.raddr_ready_o      = !r_full;
  assign bus.waddr_ready_o      = !w_full;
  assign bus.release_valid_o    = (state == Release);
  assign bus.release_id_o       = rel_id;
  assign bus.release_is_write_o = rel_is_write;
  assign bus.release_kind_o     = rel_kind;

endmodule

// File: tb/tb_simmem_row_scheduler.sv
// Scoreboard bench for simmem_row_scheduler: expected releases are queued
// in grant order and checked against each release handshake.
module tb_simmem_row_scheduler;
  import simmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  simmem_row_scheduler_if bus ();

  simmem_row_scheduler dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    bit is_write;
    int kind;
    int cost;
    int ref_cyc;
    bit chk_lat;
    bit ref_hs;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  int   m_row  = 0;
  bit   m_open = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int addr, input int len,
                                output int kind, output int cost);
    int row;
    row = (addr >> 8) & 255;
    if (!m_open) begin
      kind = 1;
      cost = 45 + 10 + len;
    end else if (row == m_row) begin
      kind = 0;
      cost = 10 + len;
    end else begin
      kind = 2;
      cost = 50 + 45 + 10 + len;
    end
    m_row  = row;
    m_open = 1;
  endfunction

  task automatic push_exp(input int id, input bit w, input int addr,
                          input int len, input bit lat, input bit hs,
                          input int rc);
    exp_t e;
    int   k, c;
    model(addr, len, k, c);
    e.id = id; e.is_write = w; e.kind = k; e.cost = c;
    e.chk_lat = lat; e.ref_hs = hs; e.ref_cyc = rc;
    q.push_back(e);
  endtask

  task automatic send(input bit w, input int id, input int addr,
                      input int len, output int acc);
    int n;
    @(negedge clk);
    if (w) begin
      bus.waddr_i.id           = IDWidth'(id);
      bus.waddr_i.addr         = AxAddrWidth'(addr);
      bus.waddr_i.burst_length = BurstLenWidth'(len);
      bus.waddr_valid_i        = 1'b1;
    end else begin
      bus.raddr_i.id           = IDWidth'(id);
      bus.raddr_i.addr         = AxAddrWidth'(addr);
      bus.raddr_i.burst_length = BurstLenWidth'(len);
      bus.raddr_valid_i        = 1'b1;
    end
    n = 0;
    while ((w ? !bus.waddr_ready_o : !bus.raddr_ready_o) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(w ? "waddr_accept" : "raddr_accept", 32'(n < 1000), 1);
    acc = cyc + 1;
    @(negedge clk);
    if (w) bus.waddr_valid_i = 1'b0;
    else bus.raddr_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    m_open = 0;
    q.delete();
  endtask

  int last_hs = 0;
  bit prev_v  = 0;
  int rise    = 0;

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (bus.release_valid_o && !prev_v) rise = cyc;
    prev_v = bus.release_valid_o;
    if (!rst && bus.release_valid_o && bus.release_ready_i) begin
      if (q.size() == 0) begin
        chk("unexpected_release", 1, 0);
      end else begin
        e = q.pop_front();
        chk("rel_id", 32'(bus.release_id_o), e.id);
        chk("rel_is_write", 32'(bus.release_is_write_o), 32'(e.is_write));
        chk("rel_kind", 32'(bus.release_kind_o), e.kind);
        if (e.chk_lat)
          chk("latency", rise - (e.ref_hs ? last_hs : e.ref_cyc), e.cost + 1);
      end
      last_hs = cyc + 1;
    end
  end

  initial begin
    int a;
    int n;
    bus.raddr_i         = '0;
    bus.waddr_i         = '0;
    bus.raddr_valid_i   = 1'b0;
    bus.waddr_valid_i   = 1'b0;
    bus.release_ready_i = 1'b1;

    do_reset();
    chk("rst_rready", 32'(bus.raddr_ready_o), 1);
    chk("rst_wready", 32'(bus.waddr_ready_o), 1);
    chk("rst_rel_valid", 32'(bus.release_valid_o), 0);
    chk("rst_rel_id", 32'(bus.release_id_o), 0);
    chk("rst_rel_is_write", 32'(bus.release_is_write_o), 0);
    chk("rst_rel_kind", 32'(bus.release_kind_o), 0);

    send(0, 3, 'h1234, 0, a);
    push_exp(3, 0, 'h1234, 0, 1, 0, a);
    wait_drain();
    send(0, 5, 'h12F0, 3, a);
    push_exp(5, 0, 'h12F0, 3, 1, 0, a);
    wait_drain();
    send(1, 2, 'h5600, 0, a);
    push_exp(2, 1, 'h5600, 0, 1, 0, a);
    wait_drain();

    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_exp(10 + i, 0, 'h1004 + i * 'h100, i, 0, 0, 0);
      push_exp(20 + i, 1, 'h1080 + i * 'h100, i, 0, 0, 0);
    end
    fork
      begin
        int ar;
        for (int i = 0; i < 3; i++) send(0, 10 + i, 'h1004 + i * 'h100, i, ar);
      end
      begin
        int aw;
        for (int i = 0; i < 3; i++) send(1, 20 + i, 'h1080 + i * 'h100, i, aw);
      end
    join
    wait_drain();

    do_reset();
    bus.release_ready_i = 1'b0;
    send(0, 7, 'h3000, 0, a);
    push_exp(7, 0, 'h3000, 0, 1, 0, a);
    n = 0;
    while (!bus.release_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_release_seen", 32'(n < 200), 1);
    send(0, 8, 'h3010, 1, a);
    chk("bp_rready_drop", 32'(bus.raddr_ready_o), 0);
    push_exp(8, 0, 'h3010, 1, 1, 1, 0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.release_valid_o), 1);
      chk("bp_id", 32'(bus.release_id_o), 7);
      chk("bp_kind", 32'(bus.release_kind_o), 1);
    end
    bus.release_ready_i = 1'b1;
    wait_drain();

    do_reset();
    send(0, 9, 'h4000, 0, a);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rready", 32'(bus.raddr_ready_o), 1);
    chk("mid_rst_wready", 32'(bus.waddr_ready_o), 1);
    chk("mid_rst_valid", 32'(bus.release_valid_o), 0);
    chk("mid_rst_id", 32'(bus.release_id_o), 0);
    rst    = 1'b0;
    m_open = 0;
    send(0, 11, 'h4000, 0, a);
    push_exp(11, 0, 'h4000, 0, 1, 0, a);
    wait_drain();

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simmem_row_scheduler.md
# simmem_row_scheduler

Serialises read-address and write-address requests onto a single simulated DRAM bank and computes a row-buffer-aware service delay for each request. Each request is held for that delay, then released toward the response banks. The block sits between the AXI address-channel input and the read-data and write-response banks. It arbitrates read against write round-robin and tracks the currently open row.

## Interface
- RowHitCost, package value 10: cycles for a row-buffer hit.
- PrechargeCost, package value 50: cycles to close the open row.
- ActivationCost, package value 45: cycles to open a row.
- clk_i  in  1  clock; the block uses one clock.
- rst_i  in  1  reset, synchronous, active-high.
- raddr_i  in  $bits(raddr_req_t)  read address request.
- raddr_valid_i  in  1  read request valid.
- raddr_ready_o  out  1  read slot empty.
- waddr_i  in  $bits(waddr_req_t)  write address request.
- waddr_valid_i  in  1  write request valid.
- waddr_ready_o  out  1  write slot empty.
- release_valid_o  out  1  serviced request available.
- release_ready_i  in  1  downstream accepts the release.
- release_id_o  out  IDWidth  AXI id of the released request.
- release_is_write_o  out  1  1 means write, 0 means read.
- release_kind_o  out  2  access kind: 0 HIT, 1 EMPTY, 2 MISS.

## Operation
- Two single-entry slots, one for read and one for write.
  - A slot loads on valid&&ready.
  - A slot frees on the cycle it is granted.
  - ready_o = !slot_full, combinational from the slot flag.
- Row number: row = addr >> RowBufferLenWidth, RowIdWidth = 8 bits.
- Open-row state:
  - open_valid resets to 0.
  - On each grant: open_row <= row and open_valid <= 1.
- Cost, computed at grant (CostWidth = 10, no overflow; maximum is 360):
  - HIT (open_valid and row match): RowHitCost + burst_length.
  - EMPTY (!open_valid): ActivationCost + RowHitCost + burst_length.
  - MISS (open_valid, rows differ): PrechargeCost + ActivationCost + RowHitCost + burst_length.
- Arbitration:
  - Only one slot full: grant that slot.
  - Both slots full: grant the side opposite to the last grant.
  - The last-grant pointer resets to "write", so read wins the first tie.
- FSM states:
  - IDLE: if any slot is full, grant, latch id/is_write/kind, load cnt = cost-1, go to SERVICE.
  - SERVICE: cnt decrements each cycle; on cnt == 0 go to RELEASE.
  - RELEASE: release_valid_o = 1; on release_ready_i go to IDLE.
- Grants occur only in IDLE. No new grant while in SERVICE or RELEASE.
- Slots keep accepting new requests during SERVICE and RELEASE.

## Timing
- Reset values:
  - raddr_ready_o = waddr_ready_o = 1.
  - release_valid_o = 0; release_id_o, release_is_write_o, release_kind_o = 0.
  - FSM = IDLE, slots empty, open_valid = 0.
- Latency: a request accepted at cycle T into an idle block is granted at T+1. release_valid_o first rises at T+1+cost.
- Release handshake and backpressure:
  - Release outputs are registered.
  - They stay stable while release_valid_o && !release_ready_i.
  - After the handshake cycle the FSM is in IDLE; the next grant comes one cycle later.
- Reset asserted in any state: on the next edge all state returns to its reset value. The in-flight request and both slot contents are dropped.

## Structure
- simmem_pkg additions:
  - RowIdWidth = AxAddrWidth - RowBufferLenWidth.
  - CostWidth = 10.
  - typedef enum logic [1:0] {RowHit, RowEmpty, RowMiss} row_access_e.
- Sub-module simmem_row_cost (combinational):
  - Inputs: addr, burst_length, open_row, open_valid.
  - Outputs: kind, cost.

## Test plan
- Reset, then read id 3, addr 0x1234, len 0, accepted at T -> release at T+56 with id 3, is_write 0, kind EMPTY (cost 55).
- Follow with read id 5, addr 0x12F0, len 3 -> kind HIT, cost 13, release 14 cycles after acceptance.
- Then write id 2, addr 0x5600, len 0 -> kind MISS, cost 105, is_write 1.
- Read and write both valid in the first cycle after reset -> read released first, then write. With both slots refilled continuously, releases alternate R, W, R, W.
- Hold release_ready_i low for 5 cycles in RELEASE -> id/kind stable, no grant, and a new read is accepted (raddr_ready_o drops). After ready, that read is granted one cycle after IDLE.
- Assert rst_i mid-SERVICE -> next cycle readies are 1 and release_valid_o is 0. The next request to the prior row reports EMPTY.
